imem_loader: RTL and testbench

Streams a program image into the processor's byte-addressed instruction memory and holds the CPU in reset until the image is complete and verified. It replaces `$readmemb` preloading for hardware bring-up and for benches that exercise the boot path. It sits between an external byte source (UART receiver or bench driver) and the write port of the instruction memory's byte storage. It also drives the processor's reset.

---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_xor_acc.sv | 30 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam int HDR_BYTES = 2;
   localparam int LEN_W     = 16;
   // Byte counter covers 4 * (2**LEN_W - 1) image bytes.
   localparam int CNT_W     = LEN_W + 2;

endpackage

// File: rtl/byte_xor_acc.sv
// 8-bit running XOR over image bytes; clear has priority over enable.
module byte_xor_acc (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   logic [7:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = 8'h00;
      else if (en)
         acc_d = acc_q ^ din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= 8'h00;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checked program image into instruction memory
// and holds the CPU in reset until the image is loaded and verified.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 2**ADDR_WIDTH/4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   state_e                  state_q, state_d;
   logic [7:0]              len_hi_q, len_hi_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]              mem_wdata_q, mem_wdata_d;
   logic                    in_ready_q, in_ready_d;
   logic                    cpu_hold_q, cpu_hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    accept;
   logic [LEN_W-1:0]        len_word;
   logic                    last_data;
   logic [7:0]              xor_val;

   // A start pulse wins over any byte offered in the same cycle.
   assign accept    = in_valid && in_ready_q && !start;
   assign len_word  = {len_hi_q, in_data};
   assign last_data = (cnt_q == ({len_q, 2'b00} - CNT_W'(1)));

   byte_xor_acc u_xor (
      .clk (clk),
      .rst (reset),
      .clr (start),
      .en  (accept && (state_q == ST_DATA)),
      .din (in_data),
      .acc (xor_val)
   );

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (start) begin
         state_d = ST_LEN_HI;
         cnt_d   = '0;
      end else if (accept) begin
         unique case (state_q)
            ST_LEN_HI: begin
               len_hi_d = in_data;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d = len_word;
               if (len_word == '0)
                  state_d = ST_CHECK;
               else if (len_word > LEN_W'(MAX_WORDS))
                  state_d = ST_ERROR;
               else
                  state_d = ST_DATA;
            end
            ST_DATA: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
               mem_wdata_d = in_data;
               cnt_d       = cnt_q + CNT_W'(1);
               if (last_data)
                  state_d = ST_CHECK;
            end
            ST_CHECK:
               state_d = (in_data == xor_val) ? ST_DONE : ST_ERROR;
            default: ;
         endcase
      end

      in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                   (state_d == ST_DATA)   || (state_d == ST_CHECK);
      done_d     = (state_d == ST_DONE);
      error_d    = (state_d == ST_ERROR);
      cpu_hold_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         len_hi_q    <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         in_ready_q  <= 1'b0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte-position reference model plus a
// memory image built from observed writes.
module tb_imem_loader;

   localparam int AW   = 10;
   localparam int MAXW = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: status 0 idle, 1 loading, 2 done, 3 error; k = bytes
   // accepted since start.
   int         status = 0;
   int         k = 0;
   int         n = 0;
   logic [7:0] hi = 8'h00;
   logic [7:0] x = 8'h00;
   logic       exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [7:0] exp_wdata = 8'h00;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         status = 0; k = 0; exp_we = 1'b0;
      end else begin
         exp_we = 1'b0;
         if (start) begin
            status = 1; k = 0; x = 8'h00;
         end else if (status == 1 && in_valid) begin
            if (k == 0) hi = in_data;
            else if (k == 1) begin
               n = {hi, in_data};
               if (n > MAXW) status = 3;
            end else if (k < 2 + 4*n) begin
               exp_we = 1'b1; exp_addr = AW'(k - 2); exp_wdata = in_data;
               x = x ^ in_data;
            end else
               status = (in_data == x) ? 2 : 3;
            k++;
         end
      end
   end

   logic [7:0]  mem [1024];
   logic [17:0] wr_q[$];
   logic [17:0] ref_q[$];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] = mem_wdata;
         wr_q.push_back({mem_addr, mem_wdata});
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, status == 1);
      chk("done",     done,     status == 2);
      chk("error",    error,    status == 3);
      chk("cpu_hold", cpu_hold, status != 2);
      chk("mem_we",   mem_we,   exp_we);
      if (exp_we) begin
         chk("mem_addr",  mem_addr,  exp_addr);
         chk("mem_wdata", mem_wdata, exp_wdata);
      end
   end

   logic [7:0] img [1024];

   function automatic logic [7:0] img_xor(input int nb);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < nb; i++) r ^= img[i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1; in_data = b;
      for (int i = 0; i < 50; i++) begin
         if (status == 1) begin
            tick(); in_valid = 1'b0; return;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic load(input int nw, input logic [7:0] c, input int gap, input bit do_start);
      if (do_start) pulse_start();
      send(8'(nw >> 8), gap);
      send(8'(nw), gap);
      for (int i = 0; i < 4*nw; i++) send(img[i], gap);
      send(c, gap);
      tick();
   endtask

   task automatic fill(input int nb);
      for (int i = 0; i < nb; i++) img[i] = 8'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      tick(); tick();
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_mem_we",    mem_we,    0);
      chk("rst_done",      done,      0);
      chk("rst_error",     error,     0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_hold",  cpu_hold,  1);
      reset = 1'b0;
      tick();

      // 6-word image back to back
      fill(24);
      wr_q.delete();
      load(6, img_xor(24), 0, 1);
      chk("t1_done", done, 1);
      chk("t1_hold", cpu_hold, 0);
      chk("t1_nwr", wr_q.size(), 24);
      for (int i = 0; i < 24 && i < wr_q.size(); i++) begin
         chk("t1_wr", wr_q[i], {AW'(i), img[i]});
         chk("t1_mem", mem[i], img[i]);
      end
      ref_q = wr_q;

      // same image with valid every third cycle
      wr_q.delete();
      load(6, img_xor(24), 2, 1);
      chk("t2_done", done, 1);
      chk("t2_nwr", wr_q.size(), ref_q.size());
      for (int i = 0; i < ref_q.size() && i < wr_q.size(); i++)
         chk("t2_wr", wr_q[i], ref_q[i]);

      // empty image
      wr_q.delete();
      load(0, 8'h00, 0, 1);
      chk("t3_done", done, 1);
      chk("t3_nwr", wr_q.size(), 0);
      load(0, 8'h5A, 0, 1);
      chk("t3_error", error, 1);
      chk("t3_hold", cpu_hold, 1);

      // bad checksum on one word; bytes still land
      img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
      chk("t4_xor", img_xor(4), 8'h22);
      load(1, 8'h00, 0, 1);
      chk("t4_error", error, 1);
      chk("t4_m0", mem[0], 8'hDE);
      chk("t4_m1", mem[1], 8'hAD);
      chk("t4_m2", mem[2], 8'hBE);
      chk("t4_m3", mem[3], 8'hEF);

      // length overflow, then recovery
      wr_q.delete();
      pulse_start();
      send(8'h01, 0); send(8'h01, 0); tick();
      chk("t5_error", error, 1);
      chk("t5_nwr", wr_q.size(), 0);
      fill(4);
      load(1, img_xor(4), 0, 1);
      chk("t5_done", done, 1);

      // reset after 10 data bytes
      fill(24);
      pulse_start();
      send(8'h00, 0); send(8'h06, 0);
      for (int i = 0; i < 10; i++) send(img[i], 0);
      reset = 1'b1; #1;
      chk("t6_hold", cpu_hold, 1);
      chk("t6_ready", in_ready, 0);
      chk("t6_we", mem_we, 0);
      tick(); reset = 1'b0; tick();
      chk("t6_idle_ready", in_ready, 0);
      load(6, img_xor(24), 0, 1);
      chk("t6_done", done, 1);
      chk("t6_hold2", cpu_hold, 0);

      // random loads, some aborted mid-data by start with a colliding byte
      for (int t = 0; t < 8; t++) begin
         int  nw, gap;
         bit  good;
         logic [7:0] c;
         nw   = $urandom_range(1, 10);
         gap  = $urandom_range(0, 2);
         good = ($urandom_range(0, 3) != 0);
         fill(4*nw);
         c = img_xor(4*nw) ^ (good ? 8'h00 : 8'(1 << $urandom_range(0, 7)));
         if (t % 3 == 1) begin
            pulse_start();
            send(8'(nw >> 8), 0); send(8'(nw), 0);
            for (int i = 0; i < int'($urandom_range(0, 4*nw-1)); i++) send(img[i], gap);
            start = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
            tick();
            start = 1'b0; in_valid = 1'b0;
            load(nw, c, gap, 0);
         end else
            load(nw, c, gap, 1);
         chk("rnd_done", done, good);
         chk("rnd_error", error, !good);
         for (int i = 0; i < 4*nw; i++) chk("rnd_mem", mem[i], img[i]);
      end

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
